// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and memory-wait controller for a five-stage pipeline.
// Priority: memory stall > redirect > load-use.
// A redirect or load-use hazard seen during a memory stall is remembered.
// It is then applied in the first cycle after the stall ends.
// Optional feature: define PIPE_CTRL_WATCHDOG_EN to add the MEMWAIT watchdog.
// The watchdog adds the wait counter and the mem_err pulse.
// Without the macro, mem_err is tied low and MEMWAIT exits only on dmem_ready.
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module pipe_ctrl #(
   parameter int WD_LIMIT = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [`RFIDX_WIDTH-1:0] rs1D,
   input  logic [`RFIDX_WIDTH-1:0] rs2D,
   input  logic [`RFIDX_WIDTH-1:0] rdE,
   input  logic                    memtoregE,
   input  logic                    regwriteE,
   input  logic                    redirectE,
   input  logic                    dmem_reqM,
   input  logic                    dmem_ready,
   output logic                    stallF,
   output logic                    stallD,
   output logic                    stallE,
   output logic                    stallM,
   output logic                    flushD,
   output logic                    flushE,
   output logic                    flushW,
   output logic                    mem_err,
   output logic                    busy
);

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

   state_t state_r;
   state_t state_nxt_s;

   logic   mem_stall_s;
   logic   loaduse_s;
   logic   redir_act_s;
   logic   lu_act_s;
   logic   wd_fire_s;
   logic   pend_redir_r;
   logic   pend_lu_r;
   logic   mem_err_r;

   // Reject an out-of-range watchdog limit at elaboration time.
   if ((WD_LIMIT < 1) || (WD_LIMIT > 15)) begin : g_wd_limit_illegal
      $error("pipe_ctrl: WD_LIMIT must be in 1..15");
   end

   assign loaduse_s   = memtoregE & regwriteE & (rdE != {`RFIDX_WIDTH{1'b0}}) &
                        ((rdE == rs1D) | (rdE == rs2D));
   assign mem_stall_s = (state_r == MEMWAIT) | (dmem_reqM & ~dmem_ready);
   // A held-over hazard counts as active once the memory stall is gone.
   assign redir_act_s = ~mem_stall_s & (redirectE | pend_redir_r);
   assign lu_act_s    = ~mem_stall_s & ~redir_act_s & (loaduse_s | pend_lu_r);

`ifdef PIPE_CTRL_WATCHDOG_EN
   localparam logic [3:0] WD_LAST = 4'(WD_LIMIT - 1);

   logic [3:0] wcnt_r;

   // Timeout only when ready is low, so a simultaneous completion wins.
   assign wd_fire_s = (state_r == MEMWAIT) & ~dmem_ready & (wcnt_r == WD_LAST);

   // Wait counter: cleared on entry to MEMWAIT, counts cycles spent waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt_r <= 4'd0;
      end else begin
         case (state_r)
            RUN: begin
               if (dmem_reqM & ~dmem_ready) wcnt_r <= 4'd0;
               else                         wcnt_r <= wcnt_r;
            end
            MEMWAIT: begin
               if (~dmem_ready & ~wd_fire_s) wcnt_r <= wcnt_r + 4'd1;
               else                          wcnt_r <= wcnt_r;
            end
            default: wcnt_r <= 4'd0;
         endcase
      end
   end
`else
   assign wd_fire_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= RUN;
      else       state_r <= state_nxt_s;
   end

   // Next-state logic: enter on an unfinished access, leave on ready or timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            if (dmem_reqM & ~dmem_ready) state_nxt_s = MEMWAIT;
            else                         state_nxt_s = RUN;
         end
         MEMWAIT: begin
            if (dmem_ready | wd_fire_s) state_nxt_s = RUN;
            else                        state_nxt_s = MEMWAIT;
         end
         default: state_nxt_s = RUN;
      endcase
   end

   // Timeout pulse, high for the single cycle after the watchdog fires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mem_err_r <= 1'b0;
      else       mem_err_r <= wd_fire_s;
   end

   // Remember hazards raised while E is frozen so they survive the stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_redir_r <= 1'b0;
         pend_lu_r    <= 1'b0;
      end else if (mem_stall_s) begin
         pend_redir_r <= pend_redir_r | redirectE;
         pend_lu_r    <= pend_lu_r | loaduse_s;
      end else begin
         pend_redir_r <= 1'b0;
         pend_lu_r    <= 1'b0;
      end
   end

   // Output logic: combinational stall/flush by priority, all low in reset.
   always_comb begin
      stallF  = 1'b0;
      stallD  = 1'b0;
      stallE  = 1'b0;
      stallM  = 1'b0;
      flushD  = 1'b0;
      flushE  = 1'b0;
      flushW  = 1'b0;
      mem_err = 1'b0;
      busy    = 1'b0;
      if (reset) begin
         busy = 1'b0;
      end else begin
         mem_err = mem_err_r;
         busy    = (state_r == MEMWAIT);
         if (mem_stall_s) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else if (redir_act_s) begin
            flushD = 1'b1;
            flushE = 1'b1;
         end else if (lu_act_s) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end else begin
            flushE = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle model checked every cycle plus
// directed vectors with hand-computed expectations.
// Output vector order: {stallF,stallD,stallE,stallM,flushD,flushE,flushW,mem_err,busy}
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module tb_pipe_ctrl;
   localparam int WD = 15;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [`RFIDX_WIDTH-1:0] rs1D, rs2D, rdE;
   logic                    memtoregE, regwriteE, redirectE, dmem_reqM, dmem_ready;
   logic                    stallF, stallD, stallE, stallM;
   logic                    flushD, flushE, flushW, mem_err, busy;
   logic [8:0]              outs;

   int n_chk  = 0;
   int n_fail = 0;

   pipe_ctrl #(.WD_LIMIT(WD)) dut (
      .clk(clk), .reset(reset),
      .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
      .memtoregE(memtoregE), .regwriteE(regwriteE), .redirectE(redirectE),
      .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushW(flushW),
      .mem_err(mem_err), .busy(busy)
   );

   assign outs = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err, busy};

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [8:0] got, input logic [8:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: whether we are waiting, how long, pending hazards.
   bit m_wait = 1'b0;
   bit m_err  = 1'b0;
   bit m_pr   = 1'b0;
   bit m_pl   = 1'b0;
   int m_cnt  = 0;

   always @(negedge clk) begin : model_cmp
      bit ms, lu, rd, lue, fire;
      logic [8:0] e;
      if (reset) begin
         cmp("model_reset", outs, 9'b0);
         m_wait = 1'b0; m_err = 1'b0; m_pr = 1'b0; m_pl = 1'b0; m_cnt = 0;
      end else begin
         ms  = m_wait || (dmem_reqM && !dmem_ready);
         lu  = memtoregE && regwriteE && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
         rd  = !ms && (redirectE || m_pr);
         lue = !ms && !rd && (lu || m_pl);
         e = 9'b0;
         if (ms)       e = 9'b111100100;
         else if (rd)  e = 9'b000011000;
         else if (lue) e = 9'b110001000;
         else          e = 9'b000000000;
         e[1] = m_err;
         e[0] = m_wait;
         cmp("model", outs, e);
         fire = 1'b0;
         if (m_wait) begin
            if (dmem_ready) m_wait = 1'b0;
`ifdef PIPE_CTRL_WATCHDOG_EN
            else if (m_cnt == WD - 1) begin m_wait = 1'b0; fire = 1'b1; end
`endif
            else m_cnt = m_cnt + 1;
         end else if (dmem_reqM && !dmem_ready) begin
            m_wait = 1'b1; m_cnt = 0;
         end
         m_err = fire;
         if (ms) begin m_pr = m_pr || redirectE; m_pl = m_pl || lu; end
         else    begin m_pr = 1'b0; m_pl = 1'b0; end
      end
   end

   task automatic set(input int r1, input int r2, input int rd, input bit mtr,
                      input bit rw, input bit rdr, input bit req, input bit rdy);
      rs1D = r1[`RFIDX_WIDTH-1:0]; rs2D = r2[`RFIDX_WIDTH-1:0]; rdE = rd[`RFIDX_WIDTH-1:0];
      memtoregE = mtr; regwriteE = rw; redirectE = rdr; dmem_reqM = req; dmem_ready = rdy;
   endtask

   // Check the current cycle's outputs, then advance to just after the next edge.
   task automatic step(input string name, input logic [8:0] exp);
      @(negedge clk); #1;
      cmp(name, outs, exp);
      @(posedge clk); #1;
   endtask

   localparam logic [8:0] ZERO = 9'b000000000;
   localparam logic [8:0] LU   = 9'b110001000;
   localparam logic [8:0] RDR  = 9'b000011000;
   localparam logic [8:0] MS0  = 9'b111100100;
   localparam logic [8:0] MS1  = 9'b111100101;
   localparam logic [8:0] BUSY = 9'b000000001;
   localparam logic [8:0] ERR  = 9'b000000010;

   initial begin
      reset = 1'b1;
      set(3, 3, 3, 1, 1, 1, 1, 0);
      step("reset_junk", ZERO);
      step("reset_junk2", ZERO);
      reset = 1'b0;
      set(0, 0, 0, 0, 0, 0, 0, 0);
      step("idle", ZERO);
      // load-use via rs2, then the load leaves E
      set(0, 5, 5, 1, 1, 0, 0, 0);  step("lu_rs2", LU);
      set(0, 5, 5, 0, 1, 0, 0, 0);  step("lu_gone", ZERO);
      set(7, 2, 7, 1, 1, 0, 0, 0);  step("lu_rs1", LU);
      set(0, 0, 0, 1, 1, 0, 0, 0);  step("lu_x0", ZERO);
      set(5, 0, 5, 1, 0, 0, 0, 0);  step("lu_nowrite", ZERO);
      set(5, 0, 5, 0, 1, 0, 0, 0);  step("alu_dep", ZERO);
      set(0, 31, 31, 1, 1, 1, 0, 0); step("redir_lu", RDR);
      set(0, 0, 0, 0, 0, 1, 0, 0);  step("redir1", RDR);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("redir_done", ZERO);
      // memory wait: ready low 3 cycles, then high
      set(0, 0, 0, 0, 0, 0, 1, 0);  step("mw_c0", MS0);
      step("mw_c1", MS1);
      step("mw_c2", MS1);
      set(0, 0, 0, 0, 0, 0, 1, 1);  step("mw_c3", MS1);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("mw_exit", ZERO);
      step("mw_noerr", ZERO);
      // memory stall outranks redirect and load-use; ready in RUN is no stall
      set(4, 0, 4, 1, 1, 1, 1, 1);  step("req_ready", RDR);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("idle2", ZERO);
      // back-to-back accesses
      set(0, 0, 0, 0, 0, 0, 1, 0);  step("b2b_a0", MS0);
      set(0, 0, 0, 0, 0, 0, 1, 1);  step("b2b_a1", MS1);
      set(0, 0, 0, 0, 0, 0, 1, 0);  step("b2b_b0", MS0);
      step("b2b_b1", MS1);
      set(0, 0, 0, 0, 0, 0, 1, 1);  step("b2b_b2", MS1);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("b2b_end", ZERO);
      // redirect held through a 2-cycle wait
      set(0, 0, 0, 0, 0, 1, 1, 0);  step("rw_c0", MS0);
      step("rw_c1", MS1);
      set(0, 0, 0, 0, 0, 1, 1, 1);  step("rw_c2", MS1);
      set(0, 0, 0, 0, 0, 1, 0, 0);  step("rw_run", RDR);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("rw_done", ZERO);
      // redirect pulsed only mid-wait must still be applied on exit
      set(0, 0, 0, 0, 0, 0, 1, 0);  step("pr_c0", MS0);
      set(0, 0, 0, 0, 0, 1, 1, 0);  step("pr_c1", MS1);
      set(0, 0, 0, 0, 0, 0, 1, 1);  step("pr_c2", MS1);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("pr_run", RDR);
      step("pr_done", ZERO);
      // load-use seen mid-wait is replayed on exit
      set(0, 0, 0, 0, 0, 0, 1, 0);  step("pl_c0", MS0);
      set(9, 0, 9, 1, 1, 0, 1, 1);  step("pl_c1", MS1);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("pl_run", LU);
      step("pl_done", ZERO);
      // reset asserted mid-wait
      set(0, 0, 0, 0, 0, 0, 1, 0);  step("rst_c0", MS0);
      step("rst_c1", MS1);
      reset = 1'b1;                 step("rst_mid", ZERO);
      reset = 1'b0;
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("rst_after", ZERO);
      step("rst_after2", ZERO);
      // watchdog / unbounded wait with ready held low
      set(0, 0, 0, 0, 0, 0, 1, 0);  step("wd_c0", MS0);
`ifdef PIPE_CTRL_WATCHDOG_EN
      for (int i = 1; i < WD; i++) step("wd_busy", MS1);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("wd_last", MS1);
      step("wd_err", ERR);
      step("wd_after", ZERO);
      // ready coinciding with the last watchdog cycle counts as completion
      set(0, 0, 0, 0, 0, 0, 1, 0);  step("wdr_c0", MS0);
      for (int i = 1; i < WD; i++) step("wdr_busy", MS1);
      set(0, 0, 0, 0, 0, 0, 1, 1);  step("wdr_last", MS1);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("wdr_noerr", ZERO);
`else
      for (int i = 1; i <= WD + 5; i++) step("nowd_busy", MS1);
      set(0, 0, 0, 0, 0, 0, 1, 1);  step("nowd_last", MS1);
      set(0, 0, 0, 0, 0, 0, 0, 0);  step("nowd_noerr", ZERO);
`endif
      step("final_idle", ZERO);
      // busy alone is never seen without stalls; guards the constant's use
      if (outs == BUSY) cmp("busy_alone", outs, ZERO);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WD_LIMIT, default 15, is the number of MEMWAIT cycles before the watchdog fires; legal range 1..15.
REQ-002 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- rs1D, rs2D  in  `RFIDX_WIDTH each  source register indices of the instruction in D.
- rdE  in  `RFIDX_WIDTH  destination register index of the instruction in E.
- memtoregE, regwriteE  in  1 each  E-stage instruction is a load / writes the register file.
- redirectE  in  1  branch or jump resolved taken in E.
- dmem_reqM  in  1  M-stage instruction is a load or store.
- dmem_ready  in  1  data memory has completed the access.
- stallF, stallD, stallE, stallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- flushD, flushE, flushW  out  1 each  clear IF/ID, ID/EX and MEM/WB to a bubble.
- mem_err  out  1  watchdog timeout pulse.
- busy  out  1  the FSM is in MEMWAIT.

Function
REQ-003 The FSM SHALL have two states, RUN and MEMWAIT, plus a 4-bit wait counter wcnt.
REQ-004 RUN->MEMWAIT SHALL occur at a clock edge when dmem_reqM=1 and dmem_ready=0.
REQ-005 MEMWAIT->RUN SHALL occur at the edge where dmem_ready=1, or where the watchdog fires (REQ-012).
REQ-006 A memory stall (state MEMWAIT, or RUN with dmem_reqM=1 and dmem_ready=0) SHALL drive the outputs combinationally as follows:
- stallF=stallD=stallE=stallM=1.
- flushW=1.
- flushD=flushE=0.
REQ-007 A redirect SHALL apply when redirectE=1 and no memory stall is active, and SHALL drive:
- flushD=1 and flushE=1.
- no stalls.
- It lasts exactly the cycles redirectE is high.
REQ-008 A load-use hazard SHALL be loaduse = memtoregE & regwriteE & (rdE!=0) & (rdE==rs1D | rdE==rs2D).
REQ-009 A load-use hazard SHALL apply only when there is no memory stall and redirectE=0, and SHALL drive:
- stallF=1, stallD=1, flushE=1.
- all other outputs 0.
REQ-010 Priority SHALL be memory stall > redirect > load-use; with none active, all stall and flush outputs SHALL be 0.
REQ-011 A redirectE or loaduse condition that arrives during MEMWAIT SHALL NOT be lost: E is frozen, so the condition SHALL be applied in the first RUN cycle after exit.
REQ-012 wcnt SHALL behave as follows:
- clear to 0 on entry to MEMWAIT.
- increment each MEMWAIT cycle with dmem_ready=0.
- When wcnt==WD_LIMIT-1 and dmem_ready=0, the FSM SHALL return to RUN and mem_err SHALL be 1 for the following cycle only.
REQ-013 If dmem_ready and the watchdog firing coincide, the access SHALL count as completed: no mem_err, return to RUN.
REQ-014 busy SHALL equal (state==MEMWAIT); the stall outputs SHALL be combinational and have no added latency.
REQ-015 Back-to-back accesses SHALL be handled: a new dmem_reqM with dmem_ready=0 in the first RUN cycle after exit SHALL re-enter MEMWAIT with wcnt cleared.

Reset
REQ-016 While reset=1 the block SHALL hold state=RUN, wcnt=0 and mem_err=0.
REQ-017 While reset=1 every output SHALL be 0, regardless of the other inputs.
REQ-018 Reset asserted mid-MEMWAIT SHALL abort the wait immediately (asynchronously), with no mem_err.

Configuration
REQ-019 With PIPE_CTRL_WATCHDOG_EN defined, the wcnt and mem_err behaviour SHALL be as in REQ-012/013.
REQ-020 Without PIPE_CTRL_WATCHDOG_EN:
- wcnt SHALL be absent.
- MEMWAIT SHALL exit only on dmem_ready.
- mem_err SHALL be tied to 0.

Verification
REQ-021 Load-use: memtoregE=1, regwriteE=1, rdE=5, rs2D=5, others 0 -> stallF=stallD=flushE=1 for 1 cycle; the next cycle with memtoregE=0 gives all outputs 0.
REQ-022 Load to x0: memtoregE=1, regwriteE=1, rdE=0, rs1D=0 -> all outputs 0.
REQ-023 Redirect plus load-use in the same cycle -> flushD=flushE=1, stallF=stallD=0.
REQ-024 Memory wait: dmem_reqM=1, dmem_ready low for 3 cycles then high -> all four stalls and flushW=1 for 4 cycles, busy=1 for 3 cycles, then RUN with no mem_err.
REQ-025 Watchdog (macro defined, WD_LIMIT=15): dmem_ready held low -> busy=1 for 15 cycles, then mem_err=1 for exactly 1 cycle, then state RUN.
REQ-026 Redirect during wait: redirectE=1 throughout a 2-cycle MEMWAIT -> flushD=flushE=0 while waiting, =1 in the first RUN cycle; reset asserted mid-wait -> all outputs 0 that cycle, busy=0 after release.
